lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, LFSR width in bits (legal range 3..32).
REQ-002 SHALL have parameter MODE, default 0, feedback form (0 = Fibonacci, 1 = Galois).
REQ-003 SHALL have parameter TAPS, default lfsr_pkg max-length mask for WIDTH, feedback tap mask (bit i set = tap at state bit i).
REQ-004 SHALL have parameter SEED_DEF, default 1, nonzero reset/recovery seed.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port en  input  1  run request; low parks generator.
REQ-008 SHALL have port seed_load  input  1  load seed into state this cycle.
REQ-009 SHALL have port seed  input  WIDTH  seed value sampled on seed_load.
REQ-010 SHALL have port random  output  WIDTH  current LFSR state, registered.
REQ-011 SHALL have port valid  output  1  random holds a value available for transfer.
REQ-012 SHALL have port ready  input  1  consumer accepts random when valid=1.
REQ-013 SHALL have port lockup  output  1  one-cycle pulse: zero seed rejected, SEED_DEF substituted.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse: sequence returned to loaded seed.
REQ-015 SHALL have port period  output  WIDTH+1  step count of last completed cycle.

Function
REQ-016 SHALL implement FSM states IDLE and RUN; valid = (state==RUN).
REQ-017 IDLE -> RUN on the first rising edge with en=1 and seed_load=0; RUN -> IDLE on edge with en=0.
REQ-018 Step = valid & ready; on a step, random SHALL update to next state at the following edge (latency 1); no step, random held.
REQ-019 Fibonacci: next = {state[WIDTH-2:0], ^(state & TAPS)}.
REQ-020 Galois: next = (state >> 1) ^ (state[0] ? TAPS_REV : 0), where TAPS_REV is TAPS bit-reversed.
REQ-021 A step coinciding with en=0 SHALL complete (random advances) while FSM enters IDLE.
REQ-022 seed_load SHALL override step and en: state <= seed, FSM -> IDLE, valid=0 next cycle; RUN resumes the cycle after if en=1.
REQ-023 seed_load with seed==0 SHALL load SEED_DEF and pulse lockup for one cycle.
REQ-024 random SHALL never be zero in any cycle.

Reset
REQ-025 reset SHALL take priority over all inputs, sampled on clk edge only.
REQ-026 Reset values: random=SEED_DEF, valid=0, FSM=IDLE, lockup=0, wrap=0, period=0, loaded-seed register=SEED_DEF, step counter=0.
REQ-027 reset asserted mid-RUN SHALL drop valid the next cycle regardless of ready.

Configuration
REQ-028 Macro LFSR_GEN_WRAP_DET_EN defined: step counter (WIDTH+1 bits) SHALL clear on reset/seed_load, increment per step; when next state equals loaded seed on a step, wrap SHALL pulse, period <= counter+1, counter <= 0.
REQ-029 Macro undefined: wrap and period SHALL be constant 0; no counter or seed-compare logic instantiated.

Structure
REQ-030 Package lfsr_pkg SHALL hold max-length tap table/function for WIDTH 3..32, MODE constants, and FSM state enum.
REQ-031 Sub-module lfsr_next SHALL compute next state combinationally from state, TAPS, MODE; lfsr_gen holds all registers.

Verification
REQ-032 WIDTH=8, MODE=0, TAPS=8'hB8, reset, en=1, ready=1 -> valid rises 1 cycle after en; random sequence 0x01,0x02,0x04,0x08,0x11.
REQ-033 Same config, wrap macro on, 255 steps -> wrap pulses once, period=255, random=0x01; MODE=1 -> period=255 as well.
REQ-034 ready toggled 1,0,0,1 in RUN -> random advances only on ready=1 cycles; value held stable while valid=1, ready=0.
REQ-035 seed_load=1, seed=0x00 in RUN -> next cycle random=0x01, lockup=1 for one cycle, valid=0 one cycle, then valid=1.
REQ-036 reset asserted during RUN with ready=0 -> next cycle valid=0, random=SEED_DEF, period=0.
REQ-037 en=0 on a step cycle -> random advances once, then valid=0 and random held until en=1.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: feedback-form constants, FSM state type and the max-length tap table
// shared by lfsr_gen and lfsr_next.
package lfsr_pkg;

    localparam int MODE_FIB    = 0;
    localparam int MODE_GALOIS = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfsr_state_e;

    // Mirror the low 'width' bits of v; bits at and above 'width' come back as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width)
                r[5'(width - 1 - i)] = v[5'(i)];
        end
        return r;
    endfunction

    // The table is written for the Fibonacci form (shift toward the MSB, feedback into bit 0).
    // In Galois form the toggle mask applied is TAPS bit-reversed, so the table entry is
    // pre-reversed to keep the toggle mask on the same max-length polynomial.
    function automatic logic [31:0] lfsr_taps(input int width, input int mode);
        logic [31:0] fib;
        case (width)
            3:       fib = 32'h0000_0006;
            4:       fib = 32'h0000_000C;
            5:       fib = 32'h0000_0014;
            6:       fib = 32'h0000_0030;
            7:       fib = 32'h0000_0060;
            8:       fib = 32'h0000_00B8;
            9:       fib = 32'h0000_0110;
            10:      fib = 32'h0000_0240;
            11:      fib = 32'h0000_0500;
            12:      fib = 32'h0000_0829;
            13:      fib = 32'h0000_100D;
            14:      fib = 32'h0000_2015;
            15:      fib = 32'h0000_6000;
            16:      fib = 32'h0000_D008;
            17:      fib = 32'h0001_2000;
            18:      fib = 32'h0002_0400;
            19:      fib = 32'h0004_0023;
            20:      fib = 32'h0009_0000;
            21:      fib = 32'h0014_0000;
            22:      fib = 32'h0030_0000;
            23:      fib = 32'h0042_0000;
            24:      fib = 32'h00E1_0000;
            25:      fib = 32'h0120_0000;
            26:      fib = 32'h0200_0023;
            27:      fib = 32'h0400_0013;
            28:      fib = 32'h0900_0000;
            29:      fib = 32'h1400_0000;
            30:      fib = 32'h2000_0029;
            31:      fib = 32'h4800_0000;
            32:      fib = 32'h8020_0003;
            default: fib = 32'h0000_0000;
        endcase
        return (mode == MODE_GALOIS) ? bit_rev(fib, width) : fib;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: combinational next-state of the LFSR in Fibonacci or Galois form.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               MODE  = MODE_FIB,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH, MODE))
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] nxt
);

    generate
        if (MODE == MODE_GALOIS) begin : g_galois
            localparam logic [WIDTH-1:0] TAPS_REV = WIDTH'(bit_rev(32'(TAPS), WIDTH));
            assign nxt = (state >> 1) ^ (state[0] ? TAPS_REV : '0);
        end else begin : g_fib
            assign nxt = {state[WIDTH-2:0], ^(state & TAPS)};
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parameterised LFSR with valid/ready output handshake and seed loading.
// Optional wrap/period detection is built when LFSR_GEN_WRAP_DET_EN is defined.
//
// state | meaning
// IDLE  | parked after reset, seed load or en=0; random held, valid=0
// RUN   | valid=1; random advances on each cycle with ready=1
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               MODE     = MODE_FIB,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_taps(WIDTH, MODE)),
    parameter logic [WIDTH-1:0] SEED_DEF = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] random,
    output logic             valid,
    input  logic             ready,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH:0]   period
);

    lfsr_state_e      state, state_nxt;
    logic             step;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] seed_val;

    lfsr_next #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .TAPS  (TAPS)
    ) u_next (
        .state (random),
        .nxt   (lfsr_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (seed_load)
            state_nxt = IDLE;
        else if (state == IDLE && en)
            state_nxt = RUN;
        else if (state == RUN && !en)
            state_nxt = IDLE;
    end

    always_comb begin
        valid = (state == RUN);
    end

    assign step     = valid & ready;
    assign seed_val = (seed == '0) ? SEED_DEF : seed;
    // Only reachable with a non-max-length TAPS; keeps the all-zero state out of random.
    assign step_val = (lfsr_nxt == '0) ? SEED_DEF : lfsr_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            random <= SEED_DEF;
            lockup <= 1'b0;
        end else if (seed_load) begin
            random <= seed_val;
            lockup <= (seed == '0);
        end else begin
            lockup <= 1'b0;
            if (step)
                random <= step_val;
        end
    end

`ifdef LFSR_GEN_WRAP_DET_EN
    logic [WIDTH-1:0] loaded_seed;
    logic [WIDTH:0]   step_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            loaded_seed <= SEED_DEF;
            step_cnt    <= '0;
            wrap        <= 1'b0;
            period      <= '0;
        end else if (seed_load) begin
            loaded_seed <= seed_val;
            step_cnt    <= '0;
            wrap        <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (step) begin
                if (step_val == loaded_seed) begin
                    wrap     <= 1'b1;
                    period   <= step_cnt + 1'b1;
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign wrap   = 1'b0;
    assign period = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed checks of lfsr_gen in Fibonacci (TAPS=0xB8) and Galois form.
// Wrap/period expectations follow LFSR_GEN_WRAP_DET_EN as defined for the build.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset, en, seed_load, ready, en_g;
    logic [7:0] seed;
    logic [7:0] random, random_g;
    logic       valid, lockup, wrap;
    logic       valid_g, lockup_g, wrap_g;
    logic [8:0] period, period_g;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lfsr_gen #(
        .WIDTH    (8),
        .MODE     (0),
        .TAPS     (8'hB8),
        .SEED_DEF (8'h01)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .seed_load (seed_load),
        .seed      (seed),
        .random    (random),
        .valid     (valid),
        .ready     (ready),
        .lockup    (lockup),
        .wrap      (wrap),
        .period    (period)
    );

    lfsr_gen #(
        .WIDTH (8),
        .MODE  (1)
    ) dut_g (
        .clk       (clk),
        .reset     (reset),
        .en        (en_g),
        .seed_load (1'b0),
        .seed      (8'h00),
        .random    (random_g),
        .valid     (valid_g),
        .ready     (1'b1),
        .lockup    (lockup_g),
        .wrap      (wrap_g),
        .period    (period_g)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fib_exp [4];
        logic [7:0] gal_exp [5];
        int         first_ret, wrap_cnt, wrap_at;
        logic       saw_zero;

        fib_exp = '{8'h02, 8'h04, 8'h08, 8'h11};
        gal_exp = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

        reset = 1'b1; en = 1'b0; seed_load = 1'b0; ready = 1'b0; seed = 8'h00; en_g = 1'b0;
        tick();
        chk("rst_random", 32'(random), 32'h01);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_lockup", 32'(lockup), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_random_g", 32'(random_g), 32'h01);
        reset = 1'b0;
        tick();
        chk("idle_valid", 32'(valid), 0);

        // basic run: valid one cycle after en, then one step per cycle
        en = 1'b1; ready = 1'b1;
        tick();
        chk("run_valid", 32'(valid), 1);
        chk("run_first", 32'(random), 32'h01);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fib_seq%0d", i), 32'(random), 32'(fib_exp[i]));
        end

        // ready pattern 1,0,0,1
        ready = 1'b1; tick(); chk("rdy_1", 32'(random), 32'h23);
        ready = 1'b0; tick(); chk("rdy_0a", 32'(random), 32'h23);
        chk("rdy_0a_valid", 32'(valid), 1);
        tick(); chk("rdy_0b", 32'(random), 32'h23);
        ready = 1'b1; tick(); chk("rdy_1b", 32'(random), 32'h47);

        // en dropped on a step cycle: step completes, then parked
        en = 1'b0;
        tick();
        chk("en0_step", 32'(random), 32'h8E);
        chk("en0_valid", 32'(valid), 0);
        tick();
        chk("en0_hold", 32'(random), 32'h8E);
        en = 1'b1;
        tick();
        chk("en1_valid", 32'(valid), 1);
        chk("en1_hold", 32'(random), 32'h8E);

        // zero seed: substitute SEED_DEF and pulse lockup
        seed_load = 1'b1; seed = 8'h00;
        tick();
        chk("zs_random", 32'(random), 32'h01);
        chk("zs_lockup", 32'(lockup), 1);
        chk("zs_valid", 32'(valid), 0);
        seed_load = 1'b0;
        tick();
        chk("zs_lockup_off", 32'(lockup), 0);
        chk("zs_valid_back", 32'(valid), 1);
        chk("zs_hold", 32'(random), 32'h01);
        tick();
        chk("zs_step", 32'(random), 32'h02);

        // nonzero seed overrides a pending step
        seed_load = 1'b1; seed = 8'hA5;
        tick();
        chk("sl_random", 32'(random), 32'hA5);
        chk("sl_lockup", 32'(lockup), 0);
        chk("sl_valid", 32'(valid), 0);
        seed_load = 1'b0;
        tick();
        chk("sl_valid_back", 32'(valid), 1);
        tick();
        chk("sl_step", 32'(random), 32'h4A);

        // full period from reset seed
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("per_valid", 32'(valid), 1);
        chk("per_start", 32'(random), 32'h01);
        first_ret = -1; wrap_cnt = 0; wrap_at = -1; saw_zero = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (random == 8'h00) saw_zero = 1'b1;
            if (random == 8'h01 && first_ret < 0) first_ret = i;
            if (wrap) begin
                wrap_cnt++;
                if (wrap_at < 0) wrap_at = i;
            end
        end
        chk("fib_return_step", 32'(first_ret), 255);
        chk("fib_no_zero", 32'(saw_zero), 0);
`ifdef LFSR_GEN_WRAP_DET_EN
        chk("fib_wrap_cnt", 32'(wrap_cnt), 1);
        chk("fib_wrap_at", 32'(wrap_at), 255);
        chk("fib_period", 32'(period), 255);
`else
        chk("fib_wrap_cnt", 32'(wrap_cnt), 0);
        chk("fib_period", 32'(period), 0);
`endif
        tick();
        chk("fib_wrap_drop", 32'(wrap), 0);
        chk("fib_after_wrap", 32'(random), 32'h02);

        // reset in RUN with ready low
        ready = 1'b0; reset = 1'b1;
        tick();
        chk("rr_valid", 32'(valid), 0);
        chk("rr_random", 32'(random), 32'h01);
        chk("rr_period", 32'(period), 0);
        reset = 1'b0; en = 1'b0;

        // Galois instance
        en_g = 1'b1;
        tick();
        chk("gal_valid", 32'(valid_g), 1);
        chk("gal_start", 32'(random_g), 32'h01);
        first_ret = -1; wrap_cnt = 0; saw_zero = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (i <= 5) chk($sformatf("gal_seq%0d", i), 32'(random_g), 32'(gal_exp[i-1]));
            if (random_g == 8'h00) saw_zero = 1'b1;
            if (random_g == 8'h01 && first_ret < 0) first_ret = i;
            if (wrap_g) wrap_cnt++;
        end
        chk("gal_return_step", 32'(first_ret), 255);
        chk("gal_no_zero", 32'(saw_zero), 0);
        chk("gal_lockup", 32'(lockup_g), 0);
`ifdef LFSR_GEN_WRAP_DET_EN
        chk("gal_wrap_cnt", 32'(wrap_cnt), 1);
        chk("gal_period", 32'(period_g), 255);
`else
        chk("gal_wrap_cnt", 32'(wrap_cnt), 0);
        chk("gal_period", 32'(period_g), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
